riscv_fetch: RTL and testbench

- Instruction fetch stage for the RV32I core, directly upstream of decode and the immediate extender.
- Owns the PC and issues word fetches to instruction memory through a request/grant handshake with in-order responses.
- Buffers returned instructions, each tagged with its PC, in a small in-order queue.
- Presents {instr, pc} to decode with a valid/ready handshake; a redirect from execute (branch/jump) flushes the queue and restarts fetch.

---
 rtl/riscv_fetch.sv | 171 +++++++++++++++++
 tb/tb_riscv_fetch.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch.sv
// riscv_fetch: RV32I instruction fetch stage.
//
// Owns the PC, issues word fetches to instruction memory over a req/gnt
// handshake (responses return in request order), buffers returned words
// tagged with their PC in a DEPTH-entry in-order queue, and presents
// {instr, pc} to decode with a valid/ready handshake. A redirect flushes
// the queue, restarts fetch at the new PC and discards the responses that
// are still owed for the old stream.
//
// Ports:
//   i_clk, i_rst                    clock (rising edge), async active-high reset
//   o_imem_req, o_imem_addr         fetch request and word-aligned address
//   i_imem_gnt                      memory accepts the request this cycle
//   i_imem_rvalid, i_imem_rdata     in-order instruction response
//   i_redirect, i_redirect_pc       flush and restart fetch at a new PC
//   o_if_valid, o_if_instr, o_if_pc instruction handed to decode
//   i_id_ready                      decode accepts this cycle

`ifndef XLEN
`define XLEN 32
`endif

module riscv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req,
    output logic [`XLEN-1:0]  o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [`XLEN-1:0]  i_imem_rdata,
    input  logic              i_redirect,
    input  logic [`XLEN-1:0]  i_redirect_pc,
    output logic              o_if_valid,
    output logic [`XLEN-1:0]  o_if_instr,
    output logic [`XLEN-1:0]  o_if_pc,
    input  logic              i_id_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [`XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // architectural fetch PC
    logic [`XLEN-1:0] pc_r;

    // queue storage: instruction word and PC tag per entry, plus filled flags
    logic [`XLEN-1:0] data_r [DEPTH];
    logic [`XLEN-1:0] tag_r  [DEPTH];
    logic [DEPTH-1:0] filled_r;

    // head = oldest entry, tail = next to allocate, fill = oldest unfilled
    logic [PTR_W-1:0] head_r;
    logic [PTR_W-1:0] tail_r;
    logic [PTR_W-1:0] fill_r;

    // allocated = in flight + filled; inflight = allocated but not yet filled;
    // drop = responses still owed for a flushed stream
    logic [CNT_W-1:0] alloc_cnt_r;
    logic [CNT_W-1:0] inflight_cnt_r;
    logic [CNT_W-1:0] drop_cnt_r;

    // last PC shown to decode, held while the queue head is empty
    logic [`XLEN-1:0] pc_hold_r;

    logic             head_valid_s;
    logic             req_s;
    logic             grant_s;
    logic             drop_s;
    logic             fill_s;
    logic             pop_s;
    logic             old_rvalid_s;

    // Handshake decode; outputs depend on state and i_redirect only.
    always_comb begin
        head_valid_s = filled_r[head_r];
        req_s        = !i_rst && !i_redirect && (alloc_cnt_r < DEPTH_C);
        grant_s      = req_s && i_imem_gnt;
        // an earlier flush still owes responses: they are older than any live entry
        drop_s       = i_imem_rvalid && (drop_cnt_r != {CNT_W{1'b0}});
        // a response with nothing outstanding is a protocol error and is ignored
        fill_s       = i_imem_rvalid && (drop_cnt_r == {CNT_W{1'b0}})
                       && (inflight_cnt_r != {CNT_W{1'b0}});
        old_rvalid_s = drop_s || fill_s;
        // redirect has priority over a pop in the same cycle
        pop_s        = head_valid_s && i_id_ready && !i_redirect;
    end

    // Output drive from queue head.
    always_comb begin
        o_imem_req  = req_s;
        o_imem_addr = {pc_r[`XLEN-1:2], 2'b00};
        o_if_valid  = head_valid_s;
        if (head_valid_s) begin
            o_if_instr = data_r[head_r];
            o_if_pc    = tag_r[head_r];
        end else begin
            o_if_instr = NOP_INSTR;
            o_if_pc    = pc_hold_r;
        end
    end

    // PC, pointers, counters and filled flags.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_r           <= RESET_PC;
            head_r         <= {PTR_W{1'b0}};
            tail_r         <= {PTR_W{1'b0}};
            fill_r         <= {PTR_W{1'b0}};
            alloc_cnt_r    <= {CNT_W{1'b0}};
            inflight_cnt_r <= {CNT_W{1'b0}};
            drop_cnt_r     <= {CNT_W{1'b0}};
            filled_r       <= {DEPTH{1'b0}};
        end else if (i_redirect) begin
            pc_r           <= {i_redirect_pc[`XLEN-1:2], 2'b00};
            head_r         <= {PTR_W{1'b0}};
            tail_r         <= {PTR_W{1'b0}};
            fill_r         <= {PTR_W{1'b0}};
            alloc_cnt_r    <= {CNT_W{1'b0}};
            inflight_cnt_r <= {CNT_W{1'b0}};
            filled_r       <= {DEPTH{1'b0}};
            // every unfilled entry still has a response coming; one arriving
            // now belongs to the old stream and is consumed here
            drop_cnt_r     <= drop_cnt_r + inflight_cnt_r - CNT_W'(old_rvalid_s);
        end else begin
            if (pop_s) begin
                filled_r[head_r] <= 1'b0;
                head_r           <= head_r + PTR_W'(1);
            end
            if (drop_s) begin
                drop_cnt_r <= drop_cnt_r - CNT_W'(1);
            end
            if (fill_s) begin
                filled_r[fill_r] <= 1'b1;
                fill_r           <= fill_r + PTR_W'(1);
            end
            if (grant_s) begin
                filled_r[tail_r] <= 1'b0;
                tail_r           <= tail_r + PTR_W'(1);
                pc_r             <= pc_r + 32'd4;
            end
            alloc_cnt_r    <= alloc_cnt_r + CNT_W'(grant_s) - CNT_W'(pop_s);
            inflight_cnt_r <= inflight_cnt_r + CNT_W'(grant_s) - CNT_W'(fill_s);
        end
    end

    // Queue payload: PC tag on grant, instruction word on fill.
    always_ff @(posedge i_clk) begin
        if (grant_s) begin
            tag_r[tail_r] <= pc_r;
        end
        if (fill_s && !i_redirect) begin
            data_r[fill_r] <= i_imem_rdata;
        end
    end

    // Remember the PC last presented so o_if_pc is stable while empty.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_hold_r <= {`XLEN{1'b0}};
        end else if (head_valid_s) begin
            pc_hold_r <= tag_r[head_r];
        end else begin
            pc_hold_r <= pc_hold_r;
        end
    end

endmodule

// File: tb/tb_riscv_fetch.sv
module tb_riscv_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam int          DEPTH  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        ready = 1'b0;

    always #5 clk = ~clk;

    riscv_fetch #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_gnt(gnt),
        .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .i_redirect(redirect), .i_redirect_pc(redirect_pc),
        .o_if_valid(if_valid), .o_if_instr(if_instr), .o_if_pc(if_pc),
        .i_id_ready(ready)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;

    // memory model: granted addresses with the cycle their response is due
    typedef struct { logic [31:0] addr; int due; } mreq_t;
    mreq_t mq[$];

    typedef struct {
        bit          g;
        bit          r;
        bit          e_req;
        logic [31:0] e_addr;
        bit          e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;
    vec_t tbl[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // called just after a falling edge: present memory response and inputs
    task automatic drive(input bit g, input bit r, input bit rd, input logic [31:0] rpc);
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            rvalid = 1'b1;
            rdata  = mq[0].addr;
        end else begin
            rvalid = 1'b0;
            rdata  = 32'hDEAD_BEEF;
        end
        gnt = g; ready = r; redirect = rd; redirect_pc = rpc;
        #1;
    endtask

    task automatic advance();
        bit          took;
        bit          rsp;
        logic [31:0] a;
        took = imem_req && gnt;
        rsp  = rvalid;
        a    = imem_addr;
        @(posedge clk);
        if (rsp) void'(mq.pop_front());
        if (took) mq.push_back('{addr: a, due: cyc + lat});
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; ready = 1'b0; redirect = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_addr",  imem_addr,     RST_PC);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr,      32'h0000_0013);
        chk("rst_pc",    if_pc,         32'h0000_0000);
        rst = 1'b0;
        mq.delete();
        cyc = 0;
    endtask

    function automatic vec_t mk(bit g, bit r, bit e_req, logic [31:0] e_addr,
                                bit e_valid, logic [31:0] e_pc, logic [31:0] e_instr);
        vec_t v;
        v.g = g; v.r = r; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc; v.e_instr = e_instr;
        return v;
    endfunction

    initial begin
        logic [31:0] exp_pc;
        int          accepted;
        bit          g, r, rd;
        logic [31:0] rpc;

        // streaming from reset, then a 5-cycle decode stall and drain
        tbl[0]  = mk(1, 1, 1, 32'h100, 0, 32'h000, 32'h13);
        tbl[1]  = mk(1, 1, 1, 32'h104, 0, 32'h000, 32'h13);
        tbl[2]  = mk(1, 1, 1, 32'h108, 1, 32'h100, 32'h100);
        tbl[3]  = mk(1, 1, 1, 32'h10C, 1, 32'h104, 32'h104);
        tbl[4]  = mk(1, 1, 1, 32'h110, 1, 32'h108, 32'h108);
        tbl[5]  = mk(1, 1, 1, 32'h114, 1, 32'h10C, 32'h10C);
        tbl[6]  = mk(1, 0, 1, 32'h118, 1, 32'h110, 32'h110);
        tbl[7]  = mk(1, 0, 1, 32'h11C, 1, 32'h110, 32'h110);
        tbl[8]  = mk(1, 0, 0, 32'h120, 1, 32'h110, 32'h110);
        tbl[9]  = mk(1, 0, 0, 32'h120, 1, 32'h110, 32'h110);
        tbl[10] = mk(1, 0, 0, 32'h120, 1, 32'h110, 32'h110);
        tbl[11] = mk(1, 1, 0, 32'h120, 1, 32'h110, 32'h110);
        tbl[12] = mk(1, 1, 1, 32'h120, 1, 32'h114, 32'h114);
        tbl[13] = mk(1, 1, 1, 32'h124, 1, 32'h118, 32'h118);
        tbl[14] = mk(1, 1, 1, 32'h128, 1, 32'h11C, 32'h11C);
        tbl[15] = mk(1, 1, 1, 32'h12C, 1, 32'h120, 32'h120);

        do_reset();
        lat = 1;
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].g, tbl[i].r, 1'b0, 32'h0);
            chk($sformatf("tbl%0d_req", i),   32'(imem_req), 32'(tbl[i].e_req));
            chk($sformatf("tbl%0d_addr", i),  imem_addr,     tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), 32'(if_valid), 32'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_pc", i),    if_pc,         tbl[i].e_pc);
            chk($sformatf("tbl%0d_instr", i), if_instr,      tbl[i].e_instr);
            advance();
        end

        // redirect with two fetches in flight (3-cycle memory)
        do_reset();
        lat = 3;
        drive(1, 1, 0, 32'h0); advance();
        drive(1, 1, 0, 32'h0); advance();
        drive(0, 1, 1, 32'h0000_2003);
        chk("redir_req_off", 32'(imem_req), 32'd0);
        advance();
        drive(1, 1, 0, 32'h0);
        chk("redir_req_on", 32'(imem_req), 32'd1);
        chk("redir_addr", imem_addr, 32'h0000_2000);
        advance();
        drive(0, 1, 0, 32'h0);
        chk("redir_addr2", imem_addr, 32'h0000_2004);
        chk("redir_drop1", 32'(if_valid), 32'd0);
        advance();
        drive(0, 1, 0, 32'h0); chk("redir_drop2", 32'(if_valid), 32'd0); advance();
        drive(0, 1, 0, 32'h0); chk("redir_wait", 32'(if_valid), 32'd0); advance();
        drive(0, 1, 0, 32'h0);
        chk("redir_valid", 32'(if_valid), 32'd1);
        chk("redir_pc", if_pc, 32'h0000_2000);
        chk("redir_instr", if_instr, 32'h0000_2000);
        advance();

        // redirect coincident with rvalid and a pop
        do_reset();
        lat = 1;
        drive(1, 1, 0, 32'h0); advance();
        drive(1, 1, 0, 32'h0); advance();
        drive(0, 1, 1, 32'h0000_3000);
        chk("coin_rvalid", 32'(rvalid), 32'd1);
        chk("coin_head", if_pc, 32'h0000_0100);
        advance();
        drive(1, 1, 0, 32'h0);
        chk("coin_flushed", 32'(if_valid), 32'd0);
        chk("coin_nop", if_instr, 32'h0000_0013);
        chk("coin_pc_hold", if_pc, 32'h0000_0100);
        chk("coin_addr", imem_addr, 32'h0000_3000);
        advance();
        drive(0, 1, 0, 32'h0); chk("coin_wait", 32'(if_valid), 32'd0); advance();
        drive(0, 1, 0, 32'h0);
        chk("coin_valid", 32'(if_valid), 32'd1);
        chk("coin_pc", if_pc, 32'h0000_3000);
        chk("coin_instr", if_instr, 32'h0000_3000);
        advance();

        // back-to-back redirects accumulate the drop count
        do_reset();
        lat = 3;
        drive(1, 1, 0, 32'h0); advance();
        drive(1, 1, 0, 32'h0); advance();
        drive(0, 1, 1, 32'h0000_4000); chk("b2b_req1", 32'(imem_req), 32'd0); advance();
        drive(1, 1, 1, 32'h0000_5000); chk("b2b_req2", 32'(imem_req), 32'd0); advance();
        drive(1, 1, 0, 32'h0);
        chk("b2b_req", 32'(imem_req), 32'd1);
        chk("b2b_addr", imem_addr, 32'h0000_5000);
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 32'h0);
            chk($sformatf("b2b_empty%0d", i), 32'(if_valid), 32'd0);
            advance();
        end
        drive(0, 1, 0, 32'h0);
        chk("b2b_valid", 32'(if_valid), 32'd1);
        chk("b2b_pc", if_pc, 32'h0000_5000);
        chk("b2b_instr", if_instr, 32'h0000_5000);
        advance();

        // PC wrap at the top of the address space
        do_reset();
        lat = 1;
        drive(0, 1, 1, 32'hFFFF_FFFC); chk("wrap_req0", 32'(imem_req), 32'd0); advance();
        drive(1, 1, 0, 32'h0); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC); advance();
        drive(1, 1, 0, 32'h0); chk("wrap_addr1", imem_addr, 32'h0000_0000); advance();
        drive(1, 1, 0, 32'h0);
        chk("wrap_pc0", if_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", if_instr, 32'hFFFF_FFFC);
        advance();
        drive(0, 1, 0, 32'h0);
        chk("wrap_valid1", 32'(if_valid), 32'd1);
        chk("wrap_pc1", if_pc, 32'h0000_0000);
        chk("wrap_instr1", if_instr, 32'h0000_0000);
        advance();

        // 3-cycle memory with random grant stalls, decode stalls and redirects
        do_reset();
        lat = 3;
        exp_pc = RST_PC;
        accepted = 0;
        for (int k = 0; k < 6000 && accepted < 200; k++) begin
            g   = ($urandom_range(0, 9) < 7);
            r   = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 39) == 0);
            rpc = $urandom;
            drive(g, r, rd, rpc);
            if (imem_addr[1:0] != 2'b00) begin
                chk("rnd_align", imem_addr, {imem_addr[31:2], 2'b00});
            end
            if (rd) begin
                exp_pc = {rpc[31:2], 2'b00};
            end else if (if_valid && r) begin
                chk("rnd_pc", if_pc, exp_pc);
                chk("rnd_instr", if_instr, exp_pc);
                exp_pc = exp_pc + 32'd4;
                accepted++;
            end
            advance();
        end
        chk("rnd_progress", 32'(accepted >= 200), 32'd1);

        // reset in the middle of traffic abandons everything
        drive(1, 1, 0, 32'h0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
